// File: rtl/led_owner_scheduler.sv
// led_owner_scheduler
//   Owns the 8 board LED lines. A fabric pattern engine drives them by default;
//   MSS software can take them over through a level request / grant handshake.
//   Every ownership change blanks the LEDs for GUARD_CYCLES cycles. A heartbeat
//   watchdog hands the LEDs back to the pattern engine if software goes quiet.
//
// Parameters
//   TICK_DIV      fabric cycles per pattern tick (>=2)
//   GUARD_CYCLES  LED blanking length on each ownership change (>=1)
//   WDG_TICKS     pattern ticks without a heartbeat edge before forced release (>=1)
//
// Ports
//   FAB_CCC_GL0   in   fabric clock, all inputs synchronous to it
//   FAB_RESET     in   synchronous active-high reset
//   MSS_READY     in   MSS is up; low forbids software ownership
//   GPIO_M2F      in   [7:0] software LED value
//   SW_REQ        in   level request for LED ownership by software
//   SW_HEARTBEAT  in   software toggles it; any edge feeds the watchdog
//   PATTERN_SEL   in   [1:0] 00 chaser, 01 blink, 10 binary count, 11 bounce
//   LED_OUT       out  [7:0] registered LED drive
//   SW_GNT        out  high only while software owns the LEDs
//   OWNER         out  [1:0] current state code
//   FAULT         out  sticky watchdog / MSS_READY-loss flag
module led_owner_scheduler #(
    parameter int TICK_DIV     = 5000000,
    parameter int GUARD_CYCLES = 16,
    parameter int WDG_TICKS    = 8
) (
    input  logic       FAB_CCC_GL0,
    input  logic       FAB_RESET,
    input  logic       MSS_READY,
    input  logic [7:0] GPIO_M2F,
    input  logic       SW_REQ,
    input  logic       SW_HEARTBEAT,
    input  logic [1:0] PATTERN_SEL,
    output logic [7:0] LED_OUT,
    output logic       SW_GNT,
    output logic [1:0] OWNER,
    output logic       FAULT
);

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam int WW = $clog2(WDG_TICKS + 1);

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES - 1);
    localparam logic [WW-1:0] WDG_LIMIT  = WW'(WDG_TICKS);

    typedef enum logic [1:0] {
        ST_PATTERN   = 2'd0,
        ST_GUARD_IN  = 2'd1,
        ST_SW        = 2'd2,
        ST_GUARD_OUT = 2'd3
    } state_t;

    state_t          state;
    logic [TW-1:0]   tick_cnt;
    logic [GW-1:0]   gcnt;
    logic [WW-1:0]   wdg;
    logic [7:0]      pat;
    logic            dir;      // bounce direction: 0 = moving left
    logic [1:0]      sel_q;    // PATTERN_SEL as seen at the last tick
    logic            hb_q;
    logic            tick;
    logic            hb_edge;
    logic            enter_pattern;

    function automatic logic [7:0] seed_of(input logic [1:0] sel);
        case (sel)
            2'b00:   seed_of = 8'h01;
            2'b01:   seed_of = 8'hFF;
            2'b10:   seed_of = 8'h00;
            default: seed_of = 8'h01;
        endcase
    endfunction

    function automatic logic [7:0] pat_next(input logic [1:0] sel, input logic [7:0] p,
                                            input logic d);
        case (sel)
            2'b00:   pat_next = {p[6:0], p[7]};
            2'b01:   pat_next = ~p;
            2'b10:   pat_next = p + 8'd1;
            default: begin
                // Reverse at the ends so 80 is followed by 40 and 01 by 02.
                if (!d) pat_next = p[7] ? (p >> 1) : (p << 1);
                else    pat_next = p[0] ? (p << 1) : (p >> 1);
            end
        endcase
    endfunction

    function automatic logic dir_next(input logic [1:0] sel, input logic [7:0] p,
                                      input logic d);
        if (sel == 2'b11) dir_next = d ? !p[0] : p[7];
        else              dir_next = 1'b0;
    endfunction

    function automatic logic [WW-1:0] wdg_sat_inc(input logic [WW-1:0] w);
        wdg_sat_inc = (w == WDG_LIMIT) ? w : w + WW'(1);
    endfunction

    always_comb begin
        tick          = (tick_cnt == TICK_LAST);
        hb_edge       = (hb_q != SW_HEARTBEAT);
        enter_pattern = (state == ST_GUARD_OUT) && (gcnt == '0);
    end

    assign OWNER = state;

    // Free-running tick divider and heartbeat sampler
    always_ff @(posedge FAB_CCC_GL0) begin
        hb_q <= SW_HEARTBEAT;
        if (FAB_RESET || tick) tick_cnt <= '0;
        else                   tick_cnt <= tick_cnt + TW'(1);
    end

    // Pattern engine
    always_ff @(posedge FAB_CCC_GL0) begin
        if (FAB_RESET) begin
            pat   <= 8'h01;
            dir   <= 1'b0;
            sel_q <= 2'b00;
        end else if (enter_pattern) begin
            // Returning from software always restarts the selected pattern.
            pat   <= seed_of(PATTERN_SEL);
            dir   <= 1'b0;
            sel_q <= PATTERN_SEL;
        end else if (tick) begin
            sel_q <= PATTERN_SEL;
            if (state == ST_PATTERN) begin
                if (PATTERN_SEL != sel_q) begin
                    pat <= seed_of(PATTERN_SEL);
                    dir <= 1'b0;
                end else begin
                    pat <= pat_next(PATTERN_SEL, pat, dir);
                    dir <= dir_next(PATTERN_SEL, pat, dir);
                end
            end
        end
    end

    // Ownership FSM with registered outputs
    always_ff @(posedge FAB_CCC_GL0) begin
        if (FAB_RESET) begin
            state   <= ST_PATTERN;
            LED_OUT <= 8'h00;
            SW_GNT  <= 1'b0;
            FAULT   <= 1'b0;
            gcnt    <= '0;
            wdg     <= '0;
        end else begin
            case (state)
                ST_PATTERN: begin
                    LED_OUT <= pat;
                    if (FAULT && !SW_REQ) FAULT <= 1'b0;
                    if (MSS_READY && SW_REQ && !FAULT) begin
                        state <= ST_GUARD_IN;
                        gcnt  <= GUARD_LOAD;
                    end
                end
                ST_GUARD_IN: begin
                    LED_OUT <= 8'h00;
                    if (!SW_REQ || !MSS_READY) begin
                        state <= ST_GUARD_OUT;
                        gcnt  <= GUARD_LOAD;
                    end else if (gcnt == '0) begin
                        state  <= ST_SW;
                        SW_GNT <= 1'b1;
                        wdg    <= '0;
                    end else begin
                        gcnt <= gcnt - GW'(1);
                    end
                end
                ST_SW: begin
                    LED_OUT <= GPIO_M2F;
                    if (hb_edge)   wdg <= '0;
                    else if (tick) wdg <= wdg_sat_inc(wdg);
                    // All exit causes merge into one transition; fault causes set FAULT.
                    if (!SW_REQ || !MSS_READY || (wdg == WDG_LIMIT)) begin
                        state  <= ST_GUARD_OUT;
                        SW_GNT <= 1'b0;
                        gcnt   <= GUARD_LOAD;
                        if (!MSS_READY || (wdg == WDG_LIMIT)) FAULT <= 1'b1;
                    end
                end
                default: begin
                    LED_OUT <= 8'h00;
                    if (gcnt == '0) state <= ST_PATTERN;
                    else            gcnt  <= gcnt - GW'(1);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_owner_scheduler.sv
module tb_led_owner_scheduler;

    localparam int TD = 4;
    localparam int GC = 3;
    localparam int WT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       ready;
    logic [7:0] gpio;
    logic       req;
    logic       hb;
    logic [1:0] sel;
    logic [7:0] led_out;
    logic       sw_gnt;
    logic [1:0] owner;
    logic       fault;

    led_owner_scheduler #(
        .TICK_DIV    (TD),
        .GUARD_CYCLES(GC),
        .WDG_TICKS   (WT)
    ) dut (
        .FAB_CCC_GL0 (clk),
        .FAB_RESET   (rst),
        .MSS_READY   (ready),
        .GPIO_M2F    (gpio),
        .SW_REQ      (req),
        .SW_HEARTBEAT(hb),
        .PATTERN_SEL (sel),
        .LED_OUT     (led_out),
        .SW_GNT      (sw_gnt),
        .OWNER       (owner),
        .FAULT       (fault)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: owner as an integer code, time spent in the current
    // state counted upward, and the pattern held as (mode, step index).
    int         m_owner, m_cin, m_cyc, m_idx, m_mode, m_latched, m_wdg;
    logic       m_fault, m_gnt, m_hb_prev;
    logic [7:0] m_led;

    function automatic logic [7:0] pat_of(input int mode, input int idx);
        int p;
        case (mode)
            0:       pat_of = 8'(1 << (idx % 8));
            1:       pat_of = (idx % 2 == 0) ? 8'hFF : 8'h00;
            2:       pat_of = 8'(idx % 256);
            default: begin
                p = idx % 14;
                pat_of = (p < 8) ? 8'(1 << p) : 8'(1 << (14 - p));
            end
        endcase
    endfunction

    task automatic m_update();
        logic tick, hbe, flt;
        int   o;
        if (rst) begin
            m_owner = 0; m_cin = 0; m_cyc = 0; m_idx = 0; m_mode = 0; m_latched = 0;
            m_wdg = 0; m_fault = 1'b0; m_gnt = 1'b0; m_led = 8'h00; m_hb_prev = hb;
            return;
        end
        tick = ((m_cyc % TD) == TD - 1);
        hbe  = (hb != m_hb_prev);
        o    = m_owner;

        if (o == 0)      m_led = pat_of(m_mode, m_idx);
        else if (o == 2) m_led = gpio;
        else             m_led = 8'h00;

        if (o == 3 && m_cin == GC - 1) begin
            m_mode = int'(sel); m_idx = 0; m_latched = int'(sel);
        end else if (tick) begin
            if (o == 0) begin
                if (int'(sel) != m_latched) begin
                    m_mode = int'(sel); m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
            m_latched = int'(sel);
        end

        case (o)
            0: begin
                if (m_fault && !req) m_fault = 1'b0;
                else if (ready && req && !m_fault) begin m_owner = 1; m_cin = 0; end
            end
            1: begin
                if (!req || !ready)      begin m_owner = 3; m_cin = 0; end
                else if (m_cin == GC - 1) begin m_owner = 2; m_cin = 0; m_wdg = 0; end
                else m_cin++;
            end
            2: begin
                flt = !ready || (m_wdg == WT);
                if (!req || flt) begin
                    m_owner = 3; m_cin = 0;
                    if (flt) m_fault = 1'b1;
                end else if (hbe) m_wdg = 0;
                else if (tick && m_wdg < WT) m_wdg++;
            end
            default: begin
                if (m_cin == GC - 1) m_owner = 0;
                else m_cin++;
            end
        endcase
        m_gnt     = (m_owner == 2);
        m_hb_prev = hb;
        m_cyc++;
    endtask

    task automatic check(input string tag);
        vectors++;
        assert (led_out === m_led) else begin
            miscompares++;
            $error("FAIL %s led_out observed=%h expected=%h", tag, led_out, m_led);
        end
        vectors++;
        assert (sw_gnt === m_gnt) else begin
            miscompares++;
            $error("FAIL %s sw_gnt observed=%b expected=%b", tag, sw_gnt, m_gnt);
        end
        vectors++;
        assert (owner === 2'(m_owner)) else begin
            miscompares++;
            $error("FAIL %s owner observed=%0d expected=%0d", tag, owner, m_owner);
        end
        vectors++;
        assert (fault === m_fault) else begin
            miscompares++;
            $error("FAIL %s fault observed=%b expected=%b", tag, fault, m_fault);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        m_update();
        #1;
        check(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        rst = 1'b1; ready = 1'b0; gpio = 8'h00; req = 1'b0; hb = 1'b0; sel = 2'b00;
        run(2, "reset");
        vectors++;
        assert (led_out === 8'h00 && owner === 2'd0 && sw_gnt === 1'b0 && fault === 1'b0) else begin
            miscompares++;
            $error("FAIL reset_outputs observed=%h/%0d/%b/%b expected=00/0/0/0",
                   led_out, owner, sw_gnt, fault);
        end
        rst = 1'b0;

        // Chaser with MSS not ready
        run(40, "chaser");

        // Software takes over, heartbeat kept alive, random GPIO values
        ready = 1'b1; req = 1'b1; gpio = 8'hA5;
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0) hb = ~hb;
            if (i > 8) gpio = 8'($urandom);
            step("sw_own");
        end

        // Voluntary release
        req = 1'b0;
        run(15, "release");

        // Watchdog expiry, then FAULT held while SW_REQ stays high
        req = 1'b1;
        run(30, "watchdog");
        req = 1'b0;
        run(6, "fault_clear");

        // Pattern selection changes
        sel = 2'b10;
        run(40, "count");
        sel = 2'b01;
        run(12, "blink");
        sel = 2'b11;
        run(70, "bounce");

        // MSS_READY lost during the entry guard
        req = 1'b1;
        run(2, "guard_in");
        ready = 1'b0;
        run(8, "guard_abort");
        ready = 1'b1; req = 1'b0;
        run(4, "recover");

        // Reset while software owns the LEDs
        req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) hb = ~hb;
            gpio = 8'($urandom);
            step("pre_reset");
        end
        rst = 1'b1;
        step("reset_in_sw");
        rst = 1'b0;
        run(3, "post_reset");

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) req = ~req;
            if ($urandom_range(0, 40) == 0) ready = ~ready;
            if ($urandom_range(0, ((i / 300) % 2 == 0) ? 2 : 9) == 0) hb = ~hb;
            if ($urandom_range(0, 50) == 0) sel = 2'($urandom);
            gpio = 8'($urandom);
            rst  = ($urandom_range(0, 300) == 0);
            step("random");
        end
        rst = 1'b0;
        run(2, "tail");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
